// File: rtl/imem_resp.sv
// -----------------------------------------------------------------------------
// imem_resp -- instruction memory with a fixed-latency read pipe and an
// in-order response FIFO.
//
// Parameters
//   DATA_W  : instruction word width
//   ADDR_W  : request byte-address width
//   AW      : word-index width (memory holds 2**AW words)
//   LATENCY : accept-to-earliest-response cycles (1..8)
//   OUTST   : maximum outstanding requests (power of two, 2..16)
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   RRdy, RAddr       : fetch request and its byte address
//   RAcc              : request accepted this cycle (combinational)
//   RVld, RData, RErr : response valid, word, access-fault flag
//   RStall            : core cannot take the response this cycle
//   WEn, WAddr, WData : word-indexed memory load port
//
// Handshake: a request transfers on a cycle with RRdy && RAcc; a response
// transfers on a cycle with RVld && !RStall.  While RVld && RStall the
// response outputs hold their values.  Responses leave in acceptance order.
// -----------------------------------------------------------------------------
module imem_resp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int AW      = 8,
  parameter int LATENCY = 2,
  parameter int OUTST   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RRdy,
  input  logic [ADDR_W-1:0] RAddr,
  output logic              RAcc,
  output logic              RVld,
  output logic [DATA_W-1:0] RData,
  output logic              RErr,
  input  logic              RStall,
  input  logic              WEn,
  input  logic [AW-1:0]     WAddr,
  input  logic [DATA_W-1:0] WData
);

  localparam int PW    = $clog2(OUTST);
  localparam int CW    = PW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int LAST  = LATENCY - 1;
  localparam logic [CW-1:0] OUTST_C = CW'(OUTST);

  // Memory array: intentionally not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Read pipe
  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_err;
  logic [DATA_W-1:0]  pipe_data [LATENCY];

  // Response FIFO
  logic [DATA_W-1:0] fifo_data [OUTST];
  logic [OUTST-1:0]  fifo_err;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;

  // Requests in the pipe plus the FIFO
  logic [CW-1:0] outst_cnt;

  logic              fault;
  logic [ADDR_W-1:0] hi_bits;
  logic [AW-1:0]     idx;
  logic              exit_vld;
  logic              fifo_empty;
  logic              xfer;
  logic              push;
  logic              pop;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign idx     = RAddr[AW+1:2];
  assign hi_bits = RAddr >> (AW + 2);
  assign fault   = (RAddr[1:0] != 2'b00) || (hi_bits != '0);

  // Credit is taken from the count at the start of the cycle, so a response
  // leaving in the same cycle does not free a slot for this cycle's request.
  assign RAcc = RRdy && !rst && (outst_cnt < OUTST_C);

  // Write lands at the edge; a same-cycle read of the same index sees the
  // old word because the pipe samples the array combinationally.
  always_ff @(posedge clk) begin
    if (WEn) begin
      mem[WAddr] <= WData;
    end
  end

  // ---------------------------------------------------------------------------
  // Fixed-latency pipe: stage 0 is loaded on the accept edge, so stage LAST
  // is visible exactly LATENCY cycles after the accept cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= RAcc;
      pipe_err[0]  <= RAcc && fault;
      pipe_data[0] <= (RAcc && !fault) ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_err[i]  <= pipe_err[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign exit_vld = pipe_vld[LAST];

  // ---------------------------------------------------------------------------
  // Response FIFO with bypass.  When the FIFO is empty the pipe exit drives
  // the outputs directly; if it is not taken that cycle it is pushed and
  // becomes the head next cycle, so the outputs stay stable under stall.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (fifo_cnt == '0);
  assign RVld       = !fifo_empty || exit_vld;
  assign xfer       = RVld && !RStall;
  assign push       = exit_vld && !(fifo_empty && xfer);
  assign pop        = !fifo_empty && xfer;

  always_comb begin
    RData = '0;
    RErr  = 1'b0;
    if (!fifo_empty) begin
      RData = fifo_data[rd_ptr];
      RErr  = fifo_err[rd_ptr];
    end else if (exit_vld) begin
      RData = pipe_data[LAST];
      RErr  = pipe_err[LAST];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fifo_err <= '0;
      for (int i = 0; i < OUTST; i++) begin
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pipe_data[LAST];
        fifo_err[wr_ptr]  <= pipe_err[LAST];
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding counter: +1 per accept, -1 per response transfer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_cnt <= '0;
    end else begin
      case ({RAcc, xfer})
        2'b10:   outst_cnt <= outst_cnt + CW'(1);
        2'b01:   outst_cnt <= outst_cnt - CW'(1);
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// -----------------------------------------------------------------------------
// tb_imem_resp -- self-checking bench for imem_resp.
// Main instance (LATENCY=2, OUTST=4) is checked against a queue-based model:
// the driver pushes the expected response of every accepted request, and
// the monitor pops and compares whenever the response should be presented.
// Two extra instances (LATENCY=1 and 8) share the inputs and are checked
// for exact response timing in a directed phase.
// -----------------------------------------------------------------------------
module tb_imem_resp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int AW     = 8;
  localparam int L      = 2;
  localparam int OUTST  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / signals
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              RRdy = 1'b0;
  logic [ADDR_W-1:0] RAddr = '0;
  logic              RStall = 1'b0;
  logic              WEn = 1'b0;
  logic [AW-1:0]     WAddr = '0;
  logic [DATA_W-1:0] WData = '0;

  logic              RAcc, RVld, RErr;
  logic [DATA_W-1:0] RData;
  logic              l1_acc, l1_vld, l1_err;
  logic [DATA_W-1:0] l1_data;
  logic              l8_acc, l8_vld, l8_err;
  logic [DATA_W-1:0] l8_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  imem_resp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AW(AW), .LATENCY(L), .OUTST(OUTST)) u_dut (
    .clk(clk), .rst(rst), .RRdy(RRdy), .RAddr(RAddr), .RAcc(RAcc), .RVld(RVld),
    .RData(RData), .RErr(RErr), .RStall(RStall), .WEn(WEn), .WAddr(WAddr), .WData(WData)
  );

  imem_resp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AW(AW), .LATENCY(1), .OUTST(OUTST)) u_l1 (
    .clk(clk), .rst(rst), .RRdy(RRdy), .RAddr(RAddr), .RAcc(l1_acc), .RVld(l1_vld),
    .RData(l1_data), .RErr(l1_err), .RStall(RStall), .WEn(WEn), .WAddr(WAddr), .WData(WData)
  );

  imem_resp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AW(AW), .LATENCY(8), .OUTST(OUTST)) u_l8 (
    .clk(clk), .rst(rst), .RRdy(RRdy), .RAddr(RAddr), .RAcc(l8_acc), .RVld(l8_vld),
    .RData(l8_data), .RErr(l8_err), .RStall(RStall), .WEn(WEn), .WAddr(WAddr), .WData(WData)
  );

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_m [1 << AW];
  logic [DATA_W:0]   exp_q [$];   // {err, data} in acceptance order
  int                acc_q [$];   // accept cycle of each expected response
  int                n_acc  = 0;  // accepts seen by the driver
  int                n_xfer = 0;  // responses retired by the monitor
  int                prev_xfer = -100;
  int                n_cmp  = 0;
  int                n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response for a byte address, from the memory-map rules.
  function automatic logic [DATA_W:0] model_resp(input logic [ADDR_W-1:0] a);
    if ((a % 4) != 0 || (a / 4) >= (1 << AW)) return {1'b1, {DATA_W{1'b0}}};
    return {1'b0, mem_m[a / 4]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver task: one cycle of stimulus, accept check, scoreboard push
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rr, input logic [ADDR_W-1:0] ad, input logic st,
                       input logic we, input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic r);
    logic exp_acc;
    @(posedge clk); #1;
    rst = r; RRdy = rr; RAddr = ad; RStall = st; WEn = we; WAddr = wa; WData = wd;
    #1;
    exp_acc = rr && !r && ((n_acc - n_xfer) < OUTST);
    check("racc", RAcc, exp_acc);
    if (exp_acc) begin
      exp_q.push_back(model_resp(ad));
      acc_q.push_back(cyc);
      n_acc++;
    end
    if (we) mem_m[wa] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    case ($urandom_range(0, 9))
      0:       a = (ADDR_W'($urandom_range(0, 255)) << 2) | ADDR_W'($urandom_range(1, 3));
      1:       a = (ADDR_W'($urandom_range(0, 255)) << 2) | (ADDR_W'(1) << $urandom_range(10, 31));
      default: a = ADDR_W'($urandom_range(0, 255)) << 2;
    endcase
    return a;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares the presented response against the queue head
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    int ready;
    if (rst) begin
      check("rst_rvld", RVld, 0);
      check("rst_rdata", RData, 0);
      check("rst_rerr", RErr, 0);
      while (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        n_xfer++;
      end
      prev_xfer = -100;
    end else if (exp_q.size() == 0) begin
      check("idle_rvld", RVld, 0);
    end else begin
      // Head is presented once its latency has elapsed and its predecessor
      // has left, whichever is later.
      ready = (acc_q[0] + L > prev_xfer + 1) ? acc_q[0] + L : prev_xfer + 1;
      if (cyc < ready) begin
        check("early_rvld", RVld, 0);
      end else begin
        check("rvld", RVld, 1);
        check("resp", {RErr, RData}, exp_q[0]);
        if (!RStall) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          prev_xfer = cyc;
          n_xfer++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [DATA_W-1:0] v;
    logic              ev;

    // Reset with a pending request: no accepts allowed.
    for (int i = 0; i < 3; i++) drive(1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Load every word so the model and the array agree.
    for (int i = 0; i < (1 << AW); i++) begin
      case (i)
        0:       v = 32'h0000_0013;
        1:       v = 32'h0010_0093;
        5:       v = 32'h0000_0000;
        default: v = $urandom();
      endcase
      drive(1'b0, '0, 1'b0, 1'b1, AW'(i), v, 1'b0);
    end
    idle(2);

    // Back-to-back fetches of words 0 and 1; all three latencies checked.
    for (int k = 0; k < 12; k++) begin
      drive(k < 2, (k == 1) ? 32'h4 : 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
      if (k < 2) begin
        check("l1_acc", l1_acc, 1);
        check("l8_acc", l8_acc, 1);
      end
      ev = (k == 1) || (k == 2);
      check("l1_vld", l1_vld, ev);
      if (ev) check("l1_data", {l1_err, l1_data}, {1'b0, (k == 1) ? 32'h0000_0013 : 32'h0010_0093});
      ev = (k == 8) || (k == 9);
      check("l8_vld", l8_vld, ev);
      if (ev) check("l8_data", {l8_err, l8_data}, {1'b0, (k == 8) ? 32'h0000_0013 : 32'h0010_0093});
    end

    // Stall with continuous requests: credit limit, then drain and resume.
    for (int k = 0; k < 8; k++)  drive(1'b1, ADDR_W'(k * 4), 1'b1, 1'b0, '0, '0, 1'b0);
    for (int k = 8; k < 18; k++) drive(1'b1, ADDR_W'(k * 4), 1'b0, 1'b0, '0, '0, 1'b0);
    idle(10);

    // Faulting addresses: misaligned and beyond the array.
    drive(1'b1, 32'h2, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(6);

    // Same-cycle write and read of index 5, then read back.
    drive(1'b1, 32'h14, 1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 32'h14, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(6);

    // Reset mid-pipe discards in-flight requests.
    drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(12);
    drive(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(6);

    // Randomized traffic with writes, stalls and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0, AW'($urandom_range(0, 255)), $urandom(),
            $urandom_range(0, 299) == 0);
    end

    // Drain and confirm nothing is left outstanding.
    idle(30);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
